pipeline_flow_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline.

---
 rtl/pipeline_flow_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_flow_ctrl
//  Brief    : Stall/flush sequencer for the 5-stage pipeline (redirect,
//             load-use bubble, multdiv wait). Optional statistics counters
//             are compiled in with PIPE_FLOW_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_flow_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int MD_TIMEOUT  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch,
    input  logic        load_use,
    input  logic        md_start,
    input  logic        md_ready,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_bubble,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [1:0]  ctrl_state
`ifdef PIPE_FLOW_STATS_EN
    ,
    output logic [31:0] stat_redirects,
    output logic [31:0] stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        REDIRECT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    localparam logic [2:0] c_RCNT_LOAD = 3'((FLUSH_DEPTH > 1) ? (FLUSH_DEPTH - 2) : 0);
    localparam logic [7:0] c_TCNT_LAST = 8'(MD_TIMEOUT - 1);

    state_t     r_state;
    logic [2:0] r_rCnt;
    logic [7:0] r_tCnt;

    state_t     w_nextState;
    logic [2:0] w_rCntNext;
    logic [7:0] w_tCntNext;

    assign ctrl_state = r_state;

    always_comb begin
        pc_we       = 1'b0;
        fd_we       = 1'b0;
        dx_we       = 1'b0;
        fd_flush    = 1'b0;
        dx_flush    = 1'b0;
        xm_bubble   = 1'b0;
        md_busy     = 1'b0;
        md_timeout  = 1'b0;
        w_nextState = r_state;
        w_rCntNext  = r_rCnt;
        w_tCntNext  = r_tCnt;

        case (r_state)
            RUN, REDIRECT: begin
                // A branch in REDIRECT is treated exactly like one in RUN.
                if (branch) begin
                    {pc_we, fd_we, dx_we} = 3'b111;
                    fd_flush   = 1'b1;
                    dx_flush   = 1'b1;
                    w_rCntNext = c_RCNT_LOAD;
                    if (FLUSH_DEPTH > 1)
                        w_nextState = REDIRECT;
                    else
                        w_nextState = RUN;
                end else if (r_state == REDIRECT) begin
                    {pc_we, fd_we, dx_we} = 3'b111;
                    fd_flush = 1'b1;
                    if (r_rCnt == 3'd0)
                        w_nextState = RUN;
                    else
                        w_rCntNext = r_rCnt - 3'd1;
                end else if (md_start) begin
                    w_nextState = MD_WAIT;
                    w_tCntNext  = 8'd0;
                end else if (load_use) begin
                    dx_we    = 1'b1;
                    dx_flush = 1'b1;
                end else begin
                    {pc_we, fd_we, dx_we} = 3'b111;
                end
            end
            MD_WAIT: begin
                md_busy = 1'b1;
                if (md_ready || (r_tCnt == c_TCNT_LAST)) begin
                    {pc_we, fd_we, dx_we} = 3'b111;
                    md_timeout  = ~md_ready;
                    w_nextState = RUN;
                end else begin
                    xm_bubble  = 1'b1;
                    w_tCntNext = r_tCnt + 8'd1;
                end
            end
            default: begin
                w_nextState = RUN;
            end
        endcase

        if (reset) begin
            pc_we      = 1'b0;
            fd_we      = 1'b0;
            dx_we      = 1'b0;
            fd_flush   = 1'b0;
            dx_flush   = 1'b0;
            xm_bubble  = 1'b0;
            md_busy    = 1'b0;
            md_timeout = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RUN;
            r_rCnt  <= 3'd0;
            r_tCnt  <= 8'd0;
        end else begin
            r_state <= w_nextState;
            r_rCnt  <= w_rCntNext;
            r_tCnt  <= w_tCntNext;
        end
    end

`ifdef PIPE_FLOW_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_redirects    <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (((r_state == RUN) || (r_state == REDIRECT)) && branch)
                stat_redirects <= stat_redirects + 32'd1;
            if ((r_state == MD_WAIT) ||
                ((r_state == RUN) && !branch && !md_start && load_use))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_flow_ctrl
//  Brief    : Directed scenarios plus randomized traffic against a cycle model
//             of the stall/flush sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_flow_ctrl;

    localparam int FD = 2;
    localparam int MT = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, branch, load_use, md_start, md_ready;
    logic pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble, md_busy, md_timeout;
    logic [1:0] ctrl_state;
`ifdef PIPE_FLOW_STATS_EN
    logic [31:0] stat_redirects, stat_stall_cycles;
`endif

    pipeline_flow_ctrl #(.FLUSH_DEPTH(FD), .MD_TIMEOUT(MT)) dut (
        .clock      (clock),
        .reset      (reset),
        .branch     (branch),
        .load_use   (load_use),
        .md_start   (md_start),
        .md_ready   (md_ready),
        .pc_we      (pc_we),
        .fd_we      (fd_we),
        .dx_we      (dx_we),
        .fd_flush   (fd_flush),
        .dx_flush   (dx_flush),
        .xm_bubble  (xm_bubble),
        .md_busy    (md_busy),
        .md_timeout (md_timeout),
        .ctrl_state (ctrl_state)
`ifdef PIPE_FLOW_STATS_EN
        ,
        .stat_redirects    (stat_redirects),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    // {pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble, md_busy, md_timeout, ctrl_state}
    logic [9:0] outs;
    assign outs = {pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_bubble, md_busy, md_timeout, ctrl_state};

    int vectors     = 0;
    int miscompares = 0;

    task automatic drive(input logic r, input logic b, input logic lu, input logic ms, input logic mr);
        @(negedge clock);
        reset    = r;
        branch   = b;
        load_use = lu;
        md_start = ms;
        md_ready = mr;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b0000000000) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", outs, 10'b0000000000);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1110000000) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", outs, 10'b1110000000);
        end
    endtask

    task automatic test_branch();
        drive(0, 1, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1111100000) begin
            miscompares++;
            $display("FAIL branch_c0: got %b expected %b", outs, 10'b1111100000);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1111000010) begin
            miscompares++;
            $display("FAIL branch_c1: got %b expected %b", outs, 10'b1111000010);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1110000000) begin
            miscompares++;
            $display("FAIL branch_c2: got %b expected %b", outs, 10'b1110000000);
        end
    endtask

    task automatic test_multdiv();
        drive(0, 0, 0, 1, 0);
        vectors++;
        if (outs !== 10'b0000000000) begin
            miscompares++;
            $display("FAIL md_issue: got %b expected %b", outs, 10'b0000000000);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0);
            vectors++;
            if (outs !== 10'b0000011001) begin
                miscompares++;
                $display("FAIL md_wait_%0d: got %b expected %b", i, outs, 10'b0000011001);
            end
        end
        drive(0, 0, 0, 0, 1);
        vectors++;
        if (outs !== 10'b1110001001) begin
            miscompares++;
            $display("FAIL md_ready: got %b expected %b", outs, 10'b1110001001);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1110000000) begin
            miscompares++;
            $display("FAIL md_after: got %b expected %b", outs, 10'b1110000000);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] expv;
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= MT; i++) begin
            drive(0, 0, 0, 0, 0);
            expv = (i < MT) ? 10'b0000011001 : 10'b1110001101;
            vectors++;
            if (outs !== expv) begin
                miscompares++;
                $display("FAIL timeout_cycle_%0d: got %b expected %b", i, outs, expv);
            end
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1110000000) begin
            miscompares++;
            $display("FAIL timeout_after: got %b expected %b", outs, 10'b1110000000);
        end
    endtask

    task automatic test_branch_load_use();
        drive(0, 1, 1, 0, 0);
        vectors++;
        if (outs !== 10'b1111100000) begin
            miscompares++;
            $display("FAIL br_lu_c0: got %b expected %b", outs, 10'b1111100000);
        end
        drive(0, 0, 1, 0, 0);
        vectors++;
        if (outs !== 10'b1111000010) begin
            miscompares++;
            $display("FAIL br_lu_redirect: got %b expected %b", outs, 10'b1111000010);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1110000000) begin
            miscompares++;
            $display("FAIL br_lu_after: got %b expected %b", outs, 10'b1110000000);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b0000000001) begin
            miscompares++;
            $display("FAIL rst_mid_wait: got %b expected %b", outs, 10'b0000000001);
        end
        drive(0, 0, 0, 0, 0);
        vectors++;
        if (outs !== 10'b1110000000) begin
            miscompares++;
            $display("FAIL rst_mid_wait_after: got %b expected %b", outs, 10'b1110000000);
        end
`ifdef PIPE_FLOW_STATS_EN
        vectors++;
        if ((stat_redirects !== 32'd0) || (stat_stall_cycles !== 32'd0)) begin
            miscompares++;
            $display("FAIL rst_stats: got %0d/%0d expected 0/0", stat_redirects, stat_stall_cycles);
        end
`endif
    endtask

    task automatic test_random();
        bit          mWait;
        int          mWaitCnt, mFlushLeft;
        logic [31:0] mRedir, mStall;
        logic        r, b, lu, ms, mr, done;
        logic [7:0]  e;
        logic [1:0]  eState;
        logic [9:0]  expv;

        drive(1, 0, 0, 0, 0);
        mWait = 0; mWaitCnt = 0; mFlushLeft = 0; mRedir = 0; mStall = 0;

        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(99) < 2);
            b  = ($urandom_range(99) < 12);
            lu = ($urandom_range(99) < 25);
            ms = ($urandom_range(99) < 12);
            mr = ($urandom_range(99) < 15);

            eState = mWait ? 2'd1 : ((mFlushLeft > 0) ? 2'd2 : 2'd0);
            done   = mWait && (mr || (mWaitCnt == MT - 1));
            if (r)                   e = 8'b00000000;
            else if (mWait)          e = done ? {6'b111000, 1'b1, ~mr} : 8'b00000110;
            else if (b)              e = 8'b11111000;
            else if (mFlushLeft > 0) e = 8'b11110000;
            else if (ms)             e = 8'b00000000;
            else if (lu)             e = 8'b00101000;
            else                     e = 8'b11100000;
            expv = {e, eState};

            drive(r, b, lu, ms, mr);
            vectors++;
            if (outs !== expv) begin
                miscompares++;
                $display("FAIL random_%0d (rst=%b br=%b lu=%b ms=%b mr=%b): got %b expected %b",
                         i, r, b, lu, ms, mr, outs, expv);
            end
`ifdef PIPE_FLOW_STATS_EN
            vectors++;
            if ((stat_redirects !== mRedir) || (stat_stall_cycles !== mStall)) begin
                miscompares++;
                $display("FAIL random_stats_%0d: got %0d/%0d expected %0d/%0d",
                         i, stat_redirects, stat_stall_cycles, mRedir, mStall);
            end
`endif
            if (r) begin
                mWait = 0; mWaitCnt = 0; mFlushLeft = 0; mRedir = 0; mStall = 0;
            end else if (mWait) begin
                mStall++;
                if (done) begin
                    mWait = 0;
                    mWaitCnt = 0;
                end else begin
                    mWaitCnt++;
                end
            end else if (b) begin
                mFlushLeft = FD - 1;
                mRedir++;
            end else if (mFlushLeft > 0) begin
                mFlushLeft--;
            end else if (ms) begin
                mWait = 1;
                mWaitCnt = 0;
            end else if (lu) begin
                mStall++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; branch = 1'b0; load_use = 1'b0; md_start = 1'b0; md_ready = 1'b0;
        test_reset();
        test_branch();
        test_multdiv();
        test_timeout();
        test_branch_load_use();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
